// File: rtl/dimmer_ctrl_if.sv
// Purpose: button/breathe inputs and step/level outputs between the dimmer_ctrl sequencer and its user.
// Latency: n/a (wires only).
// Backpressure: none; up/down are fire-and-forget pulses sampled by the dimmer every cycle.
// Signals: btn_up, btn_down, breathe (requests into the sequencer); up, down, level (step pulses and shadow level out).
interface dimmer_ctrl_if #(
  parameter int PWM_LEN = 4
);
  logic               btn_up;
  logic               btn_down;
  logic               breathe;
  logic               up;
  logic               down;
  logic [PWM_LEN-1:0] level;

  // master drives the requests, slave (the sequencer) drives the steps
  modport master (output btn_up, output btn_down, output breathe,
                  input up, input down, input level);
  modport slave  (input btn_up, input btn_down, input breathe,
                  output up, output down, output level);
endinterface

// File: rtl/dimmer_ctrl.sv
// Purpose: turns debounced button levels into single-cycle up/down steps for led_dimmer, with hold auto-repeat and optional breathe ramp.
// Latency: first step pulse 1 cycle after a request is sampled; shadow level updates on the following edge.
// Backpressure: none; steps the dimmer would ignore (saturated level) are suppressed instead of issued.
// Ports: clk, rst_n (async active-low); bus (dimmer_ctrl_if.slave): btn_up, btn_down, breathe in; up, down, level out.
// Build option: define DIMMER_BREATHE_EN to build the BREATHE state; otherwise breathe is ignored.
module dimmer_ctrl #(
  parameter int PWM_LEN        = 4,
  parameter int CNT_LEN        = 24,
  parameter int HOLD_CYCLES    = 12_500_000,
  parameter int REPEAT_CYCLES  = 5_000_000,
  parameter int BREATHE_CYCLES = 1_562_500
) (
  input logic         clk,
  input logic         rst_n,
  dimmer_ctrl_if.slave bus
);

  localparam logic [CNT_LEN-1:0] HOLD_LD    = CNT_LEN'(HOLD_CYCLES - 1);
  localparam logic [CNT_LEN-1:0] REPEAT_LD  = CNT_LEN'(REPEAT_CYCLES - 1);
  localparam logic [CNT_LEN-1:0] CNT_ONE    = CNT_LEN'(1);
  localparam logic [PWM_LEN-1:0] LVL_ONE    = PWM_LEN'(1);
  localparam logic [PWM_LEN-1:0] LVL_MAX    = '1;

`ifdef DIMMER_BREATHE_EN
  localparam logic [CNT_LEN-1:0] BREATHE_LD = CNT_LEN'(BREATHE_CYCLES - 1);
  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_REPEAT, S_BREATHE} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_REPEAT} state_t;
`endif

  state_t             r_state;
  logic [CNT_LEN-1:0] r_timer;
  logic               r_dir;      // latched button direction, 1 = up
  logic               r_up;
  logic               r_down;
  logic [PWM_LEN-1:0] r_level;
`ifdef DIMMER_BREATHE_EN
  logic               r_bdir;     // breathe direction, 1 = up
  logic               w_bdir_nxt;
  logic               w_bstep;
  logic [PWM_LEN-1:0] w_post;
`endif

  state_t             w_state_nxt;
  logic [CNT_LEN-1:0] w_timer_nxt;
  logic               w_dir_nxt;
  logic               w_step_up;
  logic               w_step_dn;
  logic               w_up_nxt;
  logic               w_dn_nxt;
  logic               w_req_up;
  logic               w_req_dn;
  logic               w_req_match;
  logic [PWM_LEN-1:0] w_level_eff;
  logic               w_can_up;
  logic               w_can_dn;

  assign w_req_up    = bus.btn_up & ~bus.btn_down;
  assign w_req_dn    = bus.btn_down & ~bus.btn_up;
  assign w_req_match = r_dir ? w_req_up : w_req_dn;

  // Level the dimmer will hold when the step decided now reaches it:
  // an in-flight pulse is applied on the same edge this decision registers.
  always_comb begin
    w_level_eff = r_level;
    if (r_up)
      w_level_eff = r_level + LVL_ONE;
    else if (r_down)
      w_level_eff = r_level - LVL_ONE;
  end

  assign w_can_up = (w_level_eff != LVL_MAX);
  assign w_can_dn = (w_level_eff > LVL_ONE);

  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_dir_nxt   = r_dir;
    w_step_up   = 1'b0;
    w_step_dn   = 1'b0;
`ifdef DIMMER_BREATHE_EN
    w_bdir_nxt  = r_bdir;
    w_bstep     = 1'b0;
    w_post      = w_level_eff;
`endif

    case (r_state)
      S_IDLE: begin
        if (w_req_up || w_req_dn) begin
          w_step_up   = w_req_up;
          w_step_dn   = w_req_dn;
          w_dir_nxt   = w_req_up;
          w_timer_nxt = HOLD_LD;
          w_state_nxt = S_HOLD;
        end
`ifdef DIMMER_BREATHE_EN
        else if (bus.breathe) begin
          w_timer_nxt = BREATHE_LD;
          w_state_nxt = S_BREATHE;
        end
`endif
      end

      S_HOLD, S_REPEAT: begin
        if (!w_req_match) begin
          w_state_nxt = S_IDLE;
        end else if (r_timer == '0) begin
          w_step_up   = r_dir;
          w_step_dn   = ~r_dir;
          w_timer_nxt = REPEAT_LD;
          w_state_nxt = S_REPEAT;
        end else begin
          w_timer_nxt = r_timer - CNT_ONE;
        end
      end

`ifdef DIMMER_BREATHE_EN
      S_BREATHE: begin
        // A button request leaves without stepping; IDLE serves it next cycle.
        if (w_req_up || w_req_dn || !bus.breathe) begin
          w_state_nxt = S_IDLE;
        end else if (r_timer == '0) begin
          w_step_up   = r_bdir;
          w_step_dn   = ~r_bdir;
          w_bstep     = 1'b1;
          w_timer_nxt = BREATHE_LD;
        end else begin
          w_timer_nxt = r_timer - CNT_ONE;
        end
      end
`endif

      default: w_state_nxt = S_IDLE;
    endcase

    // Saturated steps are dropped here so every branch above stays uniform.
    w_up_nxt = w_step_up & w_can_up;
    w_dn_nxt = w_step_dn & w_can_dn;

`ifdef DIMMER_BREATHE_EN
    // Flip on the level after this step; a suppressed step still flips so
    // the ramp cannot stall against a rail.
    if (w_up_nxt)
      w_post = w_level_eff + LVL_ONE;
    else if (w_dn_nxt)
      w_post = w_level_eff - LVL_ONE;
    if (w_bstep) begin
      if (w_post == LVL_ONE)
        w_bdir_nxt = 1'b1;
      else if (w_post == LVL_MAX)
        w_bdir_nxt = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_timer <= '0;
      r_dir   <= 1'b0;
      r_up    <= 1'b0;
      r_down  <= 1'b0;
      r_level <= LVL_MAX;
`ifdef DIMMER_BREATHE_EN
      r_bdir  <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
      r_dir   <= w_dir_nxt;
      r_up    <= w_up_nxt;
      r_down  <= w_dn_nxt;
      // Mirrors the dimmer, which samples the pulse on this same edge.
      if (r_up)
        r_level <= r_level + LVL_ONE;
      else if (r_down)
        r_level <= r_level - LVL_ONE;
`ifdef DIMMER_BREATHE_EN
      r_bdir  <= w_bdir_nxt;
`endif
    end
  end

  assign bus.up    = r_up;
  assign bus.down  = r_down;
  assign bus.level = r_level;

endmodule

// File: tb/tb_dimmer_ctrl.sv
// Directed bench for dimmer_ctrl with HOLD=8, REPEAT=4, BREATHE=2, PWM_LEN=4.
module tb_dimmer_ctrl;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_fail;

  dimmer_ctrl_if #(.PWM_LEN(4)) bus();

  dimmer_ctrl #(
    .PWM_LEN       (4),
    .CNT_LEN       (8),
    .HOLD_CYCLES   (8),
    .REPEAT_CYCLES (4),
    .BREATHE_CYCLES(2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Returns 1 time unit after a rising edge: outputs are settled, inputs set
  // here are sampled by the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hold(input logic u, input logic d, input int n,
                      output logic [63:0] mu, output logic [63:0] md);
    bus.btn_up   = u;
    bus.btn_down = d;
    mu = '0;
    md = '0;
    for (int i = 1; i <= n; i++) begin
      tick();
      mu[i] = bus.up;
      md[i] = bus.down;
    end
  endtask

  task automatic tap(input logic u, output int n_up, output int n_dn);
    n_up = 0;
    n_dn = 0;
    bus.btn_up   = u;
    bus.btn_down = ~u;
    tick();
    n_up += int'(bus.up);
    n_dn += int'(bus.down);
    bus.btn_up   = 1'b0;
    bus.btn_down = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_up += int'(bus.up);
      n_dn += int'(bus.down);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    int n_pulse;
    rst_n        = 1'b0;
    bus.btn_up   = 1'b0;
    bus.btn_down = 1'b0;
    bus.breathe  = 1'b0;
    tick();
    tick();
    n_cmp++;
    if (bus.up !== 1'b0 || bus.down !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_pulses: got up=%b down=%b expected 0/0", bus.up, bus.down);
    end
    n_cmp++;
    if (bus.level !== 4'd15) begin
      n_fail++;
      $display("FAIL reset_level: got %0d expected 15", bus.level);
    end
    rst_n = 1'b1;
    n_pulse = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      n_pulse += int'(bus.up) + int'(bus.down);
    end
    n_cmp++;
    if (n_pulse !== 0) begin
      n_fail++;
      $display("FAIL idle_pulses: got %0d expected 0", n_pulse);
    end
    n_cmp++;
    if (bus.level !== 4'd15) begin
      n_fail++;
      $display("FAIL idle_level: got %0d expected 15", bus.level);
    end
  endtask

  task automatic test_hold_repeat();
    logic [63:0] mu, md;
    hold(1'b0, 1'b1, 30, mu, md);
    n_cmp++;
    if (md !== 64'h22222202) begin
      n_fail++;
      $display("FAIL hold_down_times: got %h expected %h", md, 64'h22222202);
    end
    n_cmp++;
    if (mu !== 64'h0) begin
      n_fail++;
      $display("FAIL hold_no_up: got %h expected 0", mu);
    end
    n_cmp++;
    if (bus.level !== 4'd8) begin
      n_fail++;
      $display("FAIL hold_level: got %0d expected 8", bus.level);
    end
    bus.btn_down = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_saturate_low();
    logic [63:0] mu, md;
    int nu, nd, tot_dn;
    tot_dn = 0;
    for (int i = 0; i < 5; i++) begin
      tap(1'b0, nu, nd);
      tot_dn += nd;
    end
    n_cmp++;
    if (tot_dn !== 5 || bus.level !== 4'd3) begin
      n_fail++;
      $display("FAIL tap_down: got %0d pulses level %0d expected 5 pulses level 3", tot_dn, bus.level);
    end
    hold(1'b0, 1'b1, 20, mu, md);
    n_cmp++;
    if (md !== 64'h202) begin
      n_fail++;
      $display("FAIL floor_down_times: got %h expected %h", md, 64'h202);
    end
    n_cmp++;
    if (bus.level !== 4'd1) begin
      n_fail++;
      $display("FAIL floor_level: got %0d expected 1", bus.level);
    end
    bus.btn_down = 1'b0;
    tick();
    tap(1'b1, nu, nd);
    n_cmp++;
    if (nu !== 1 || nd !== 0) begin
      n_fail++;
      $display("FAIL tap_up: got up=%0d down=%0d expected 1/0", nu, nd);
    end
    n_cmp++;
    if (bus.level !== 4'd2) begin
      n_fail++;
      $display("FAIL tap_up_level: got %0d expected 2", bus.level);
    end
  endtask

  task automatic test_ceiling_and_both();
    logic [63:0] mu, md;
    int nu, nd;
    do_reset();
    hold(1'b1, 1'b0, 20, mu, md);
    n_cmp++;
    if (mu !== 64'h0 || md !== 64'h0) begin
      n_fail++;
      $display("FAIL ceiling_pulses: got up=%h down=%h expected 0/0", mu, md);
    end
    n_cmp++;
    if (bus.level !== 4'd15) begin
      n_fail++;
      $display("FAIL ceiling_level: got %0d expected 15", bus.level);
    end
    bus.btn_up = 1'b0;
    tick();
    hold(1'b0, 1'b1, 14, mu, md);
    n_cmp++;
    if (md !== 64'h2202) begin
      n_fail++;
      $display("FAIL repeat_times: got %h expected %h", md, 64'h2202);
    end
    hold(1'b1, 1'b1, 10, mu, md);
    n_cmp++;
    if (mu !== 64'h0 || md !== 64'h0) begin
      n_fail++;
      $display("FAIL both_pulses: got up=%h down=%h expected 0/0", mu, md);
    end
    n_cmp++;
    if (bus.level !== 4'd12) begin
      n_fail++;
      $display("FAIL both_level: got %0d expected 12", bus.level);
    end
    bus.btn_up   = 1'b0;
    bus.btn_down = 1'b0;
    tick();
    // Back in IDLE: a fresh press steps on the very first edge.
    tap(1'b0, nu, nd);
    n_cmp++;
    if (nd !== 1 || bus.level !== 4'd11) begin
      n_fail++;
      $display("FAIL after_both: got %0d pulses level %0d expected 1 pulse level 11", nd, bus.level);
    end
  endtask

  task automatic test_async_reset();
    logic [63:0] mu, md;
    hold(1'b0, 1'b1, 9, mu, md);
    n_cmp++;
    if (bus.down !== 1'b1 || md !== 64'h202) begin
      n_fail++;
      $display("FAIL pre_reset_repeat: got down=%b times %h expected 1 %h", bus.down, md, 64'h202);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.down !== 1'b0 || bus.up !== 1'b0 || bus.level !== 4'd15) begin
      n_fail++;
      $display("FAIL async_reset: got up=%b down=%b level=%0d expected 0 0 15", bus.up, bus.down, bus.level);
    end
    bus.btn_down = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
    tick();
    n_cmp++;
    if (bus.down !== 1'b0 || bus.level !== 4'd15) begin
      n_fail++;
      $display("FAIL post_reset: got down=%b level=%0d expected 0 15", bus.down, bus.level);
    end
  endtask

`ifdef DIMMER_BREATHE_EN
  task automatic test_breathe();
    logic exp_up, exp_dn;
    int   k;
    bus.breathe = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      tick();
      exp_up = 1'b0;
      exp_dn = 1'b0;
      if (i >= 3 && (i % 2) == 1) begin
        k = (i - 3) / 2;
        if (k < 14 || k >= 28) exp_dn = 1'b1;
        else exp_up = 1'b1;
      end
      n_cmp++;
      if (bus.up !== exp_up || bus.down !== exp_dn) begin
        n_fail++;
        $display("FAIL breathe_cycle_%0d: got up=%b down=%b expected %b %b", i, bus.up, bus.down, exp_up, exp_dn);
      end
      if (i == 30) begin
        n_cmp++;
        if (bus.level !== 4'd1) begin
          n_fail++;
          $display("FAIL breathe_floor: got %0d expected 1", bus.level);
        end
      end
    end
    n_cmp++;
    if (bus.level !== 4'd14) begin
      n_fail++;
      $display("FAIL breathe_level_60: got %0d expected 14", bus.level);
    end
    bus.btn_up = 1'b1;
    tick();
    n_cmp++;
    if (bus.up !== 1'b0 || bus.down !== 1'b0) begin
      n_fail++;
      $display("FAIL preempt_quiet: got up=%b down=%b expected 0 0", bus.up, bus.down);
    end
    tick();
    n_cmp++;
    if (bus.up !== 1'b1 || bus.down !== 1'b0) begin
      n_fail++;
      $display("FAIL preempt_up: got up=%b down=%b expected 1 0", bus.up, bus.down);
    end
    tick();
    n_cmp++;
    if (bus.level !== 4'd15) begin
      n_fail++;
      $display("FAIL preempt_level: got %0d expected 15", bus.level);
    end
    bus.btn_up  = 1'b0;
    bus.breathe = 1'b0;
    tick();
    tick();
  endtask
`else
  task automatic test_breathe_disabled();
    int n_pulse;
    n_pulse = 0;
    bus.breathe = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      n_pulse += int'(bus.up) + int'(bus.down);
    end
    n_cmp++;
    if (n_pulse !== 0) begin
      n_fail++;
      $display("FAIL breathe_off_pulses: got %0d expected 0", n_pulse);
    end
    n_cmp++;
    if (bus.level !== 4'd15) begin
      n_fail++;
      $display("FAIL breathe_off_level: got %0d expected 15", bus.level);
    end
    bus.breathe = 1'b0;
    tick();
  endtask
`endif

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_hold_repeat();
    test_saturate_low();
    test_ceiling_and_both();
    test_async_reset();
`ifdef DIMMER_BREATHE_EN
    test_breathe();
`else
    test_breathe_disabled();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/dimmer_ctrl.md
# dimmer_ctrl

Sequencer for the `led_dimmer` brightness level on the IO shield. It turns two debounced push-button levels into single-cycle `up`/`down` step pulses, with press-and-hold auto-repeat and an optional free-running "breathe" ramp. It also keeps a shadow copy of the dimmer level so that it never issues a step the dimmer would ignore. Its outputs connect directly to the dimmer's `up`/`down` inputs, and both blocks run on the same clock.

## Interface
- `PWM_LEN`, 4: width of the dimmer level; must match the dimmer's `PWM_LEN`.
- `CNT_LEN`, 24: width of the internal interval timer.
- `HOLD_CYCLES`, 12_500_000: cycles from the first step to the first auto-repeat step (250 ms at 50 MHz).
- `REPEAT_CYCLES`, 5_000_000: cycles between auto-repeat steps.
- `BREATHE_CYCLES`, 1_562_500: cycles between breathe steps.
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `btn_up`  in  1  debounced, synchronous level; high means "brighter" is held.
- `btn_down`  in  1  debounced, synchronous level; high means "dimmer" is held.
- `breathe`  in  1  level; enables the breathe ramp when no button request is present.
- `up`  out  1  registered one-cycle step-up pulse to the dimmer.
- `down`  out  1  registered one-cycle step-down pulse to the dimmer.
- `level`  out  PWM_LEN  shadow of the dimmer level.

## Operation
- Request decode (combinational):
  - REQ_UP = `btn_up & ~btn_down`.
  - REQ_DN = `btn_down & ~btn_up`.
  - Both buttons high, or both low, means no request.
- States: IDLE, HOLD, REPEAT, BREATHE.
- IDLE:
  - On REQ_UP/REQ_DN: issue a step in that direction, latch the direction, load the timer with HOLD_CYCLES-1, go to HOLD.
  - Otherwise, if `breathe` is high: load the timer with BREATHE_CYCLES-1 and go to BREATHE.
- HOLD and REPEAT:
  - Each cycle the request does not equal the latched direction (release, reversal, or both buttons pressed), go to IDLE with no pulse.
  - Otherwise the timer decrements. At 0: issue a step, reload with REPEAT_CYCLES-1, go to (or stay in) REPEAT.
- BREATHE:
  - Any button request goes to IDLE with no pulse. The request is then serviced from IDLE on the next cycle.
  - `breathe` low goes to IDLE; the level is held.
  - Otherwise the timer counts down. At 0: issue a step in the breathe direction and reload.
  - The breathe direction flips to up when the post-step level is 1, and to down when it is all ones.
- Step saturation follows the dimmer rules:
  - An up step is suppressed (no pulse) when `level` is all ones.
  - A down step is suppressed when `level` ≤ 1.
  - A suppressed step still advances the timer and state normally.
- Shadow update: `level` increments or decrements on the same edge where the dimmer samples the pulse. It always equals the dimmer's `level_q`.
- `up` and `down` are never high together, and each is high for at most one cycle per step.
- Reset values (async, on `rst_n` low, including mid-operation):
  - state IDLE; `up` = `down` = 0.
  - `level` = all ones (matches the dimmer reset); timer = 0; breathe direction = down.
- The timer is loaded and compared at CNT_LEN bits. All `*_CYCLES` values must be between 1 and 2^CNT_LEN inclusive.

## Timing
- Press latency: if `btn_up` is first sampled high at edge n, `up` is high for the cycle after edge n, and `level` shows the new value after edge n+1.
- Hold: the first pulse is at cycle t. The second is at t+HOLD_CYCLES. Later pulses come every REPEAT_CYCLES.
- Breathe: the first pulse comes BREATHE_CYCLES cycles after entering BREATHE, then every BREATHE_CYCLES.
- Release or reversal: no pulse is issued in the cycle after the edge that samples the change.
- After a button request preempts BREATHE, the first button pulse comes 2 cycles after the request is first sampled.

## Configuration
- Macro `DIMMER_BREATHE_EN`.
- Defined: the BREATHE state and breathe direction register are built, and `breathe` operates as described above.
- Undefined: the BREATHE state is removed and `breathe` is ignored (the port is kept). IDLE stays idle whenever there is no button request.

## Test plan
All scenarios use `PWM_LEN`=4, `HOLD_CYCLES`=8, `REPEAT_CYCLES`=4, `BREATHE_CYCLES`=2.
- Reset, then idle 20 cycles → `up`=`down`=0 and `level`=15. Deassert `rst_n` mid-REPEAT → outputs clear immediately and `level`=15.
- Hold `btn_down` for 30 cycles from `level`=15 → `down` pulses at t, t+8, t+12, t+16, t+20, t+24, t+28 → `level`=8.
- Hold `btn_down` from `level`=3 → `level` goes 2, then 1, and stops. No further `down` pulses while held. Then tap `btn_up` once → exactly one `up` pulse and `level`=2.
- Hold `btn_up` at `level`=15 → no pulses. Press both buttons during REPEAT → pulses stop immediately and the state returns to IDLE.
- With `DIMMER_BREATHE_EN` defined, hold `breathe` high from `level`=15 → `down` every 2 cycles until `level`=1, then `up` every 2 cycles until 15, repeating. Assert `btn_up` mid-ramp → the breathe ramp stops and an `up` pulse follows 2 cycles after `btn_up` is first sampled.
- With `DIMMER_BREATHE_EN` undefined, hold `breathe` high for 100 cycles → no pulses and `level` stays constant.
